// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the signed-divide sign controller.
//   DIV_W   : operand / result width (32)
//   OP_W    : width of the magnitude operands sent to the unsigned divider (33)
//   CNT_W   : width of the latency counter (covers DIV_LATENCY up to 255)
//   div_state_e : controller FSM states IDLE, WAIT, DONE
//   neg32() : 32-bit two's-complement negation (wraps, so -0x80000000 stays
//             0x80000000)
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W = 32;
    localparam int OP_W  = 33;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] neg32(input logic [DIV_W-1:0] value);
        return (~value) + {{(DIV_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_sign_ctrl_sign_mag.sv
// ----------------------------------------------------------------------------
// sign_mag
// Combinational split of a signed two's-complement value into sign and
// magnitude. The magnitude of the most negative value wraps to itself
// (0x80000000), which is still correct when read as an unsigned number.
// Ports:
//   value : in  32  signed operand
//   mag   : out 32  unsigned magnitude |value|
//   sign  : out 1   value[31]
// ----------------------------------------------------------------------------
module sign_mag
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] value,
    output logic [DIV_W-1:0] mag,
    output logic             sign
);

    assign sign = value[DIV_W-1];
    assign mag  = sign ? neg32(value) : value;

endmodule

// File: rtl/div_sign_ctrl.sv
// ----------------------------------------------------------------------------
// div_sign_ctrl
// Wraps an external unsigned divider to perform signed 32-bit division
// (truncate toward zero, remainder takes the dividend's sign). Operand
// magnitudes are registered on acceptance, the controller waits DIV_LATENCY
// edges for the divider to settle, then applies the sign fix-up to the
// quotient (LO) and remainder (HI).
//
// Build option: define DIV_ZERO_TRAP_EN to short-circuit a zero divisor
// straight to DONE with hi=dividend, lo=0xFFFFFFFF, div_zero=1. Without it
// a zero divisor takes the normal path and div_zero is tied low.
//
// Ports:
//   clk           : in  1   clock, rising edge
//   clr_n         : in  1   asynchronous active-low reset
//   start         : in  1   request; accepted only while idle
//   dividend      : in  32  signed dividend
//   divisor       : in  32  signed divisor
//   div_m         : out 33  {1'b0,|divisor|} to unsigned divider
//   div_q         : out 33  {1'b0,|dividend|} to unsigned divider
//   div_quotient  : in  32  unsigned quotient from divider
//   div_remainder : in  32  unsigned remainder from divider
//   lo            : out 32  signed quotient
//   hi            : out 32  signed remainder
//   busy          : out 1   state is not IDLE
//   done          : out 1   one-cycle pulse, hi/lo/div_zero valid
//   div_zero      : out 1   divide-by-zero flag
//
// Handshake: start is a request sampled on a rising edge while busy is low;
// that edge is the acceptance. Requests while busy are dropped, not queued.
// done pulses for exactly one cycle per accepted request that is not aborted
// by reset.
// ----------------------------------------------------------------------------
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int DIV_LATENCY = 33
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [OP_W-1:0]  div_m,
    output logic [OP_W-1:0]  div_q,
    input  logic [DIV_W-1:0] div_quotient,
    input  logic [DIV_W-1:0] div_remainder,
    output logic [DIV_W-1:0] lo,
    output logic [DIV_W-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    div_state_e       state;
    div_state_e       state_next;
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;

    logic [DIV_W-1:0] dividend_mag;
    logic [DIV_W-1:0] divisor_mag;
    logic             dividend_neg;
    logic             divisor_neg;

    logic             accept;
    logic             capture;
    logic             trap;

    sign_mag u_dividend_mag (
        .value (dividend),
        .mag   (dividend_mag),
        .sign  (dividend_neg)
    );

    sign_mag u_divisor_mag (
        .value (divisor),
        .mag   (divisor_mag),
        .sign  (divisor_neg)
    );

    assign accept  = (state == IDLE) && start;
    assign capture = (state == WAIT) && (count == '0);

`ifdef DIV_ZERO_TRAP_EN
    logic div_zero_r;

    assign trap = (divisor == '0);

    // Set only by a trapped request; any normal capture clears it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_zero_r <= 1'b0;
        end else if (accept && trap) begin
            div_zero_r <= 1'b1;
        end else if (capture) begin
            div_zero_r <= 1'b0;
        end
    end

    assign div_zero = div_zero_r;
`else
    assign trap     = 1'b0;
    assign div_zero = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = trap ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand, counter and result registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_m  <= '0;
            div_q  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            count  <= '0;
            lo     <= '0;
            hi     <= '0;
        end else if (accept) begin
            div_m  <= {1'b0, divisor_mag};
            div_q  <= {1'b0, dividend_mag};
            sign_q <= dividend_neg ^ divisor_neg;
            sign_r <= dividend_neg;
            count  <= CNT_LOAD;
            if (trap) begin
                hi <= dividend;
                lo <= '1;
            end
        end else if (state == WAIT) begin
            if (count == '0) begin
                lo <= sign_q ? neg32(div_quotient)  : div_quotient;
                hi <= sign_r ? neg32(div_remainder) : div_remainder;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_sign_ctrl.sv
module tb_div_sign_ctrl;

    localparam int LAT = 33;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [32:0] div_m;
    logic [32:0] div_q;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    // expected response: {div_zero, hi, lo}
    logic [64:0] exp_q[$];

    div_sign_ctrl #(.DIV_LATENCY(LAT)) dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_m         (div_m),
        .div_q         (div_q),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .lo            (lo),
        .hi            (hi),
        .busy          (busy),
        .done          (done),
        .div_zero      (div_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned divider stand-in; divide by zero returns all-ones / dividend.
    always_comb begin
        if (div_m == '0) begin
            div_quotient  = '1;
            div_remainder = div_q[31:0];
        end else begin
            div_quotient  = 32'(div_q / div_m);
            div_remainder = 32'(div_q % div_m);
        end
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 65'd1, 65'd0);
            end else begin
                check("result", {div_zero, hi, lo}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // poke >= 0 pulses start with other operands that many cycles into WAIT.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_z,
                           input logic [32:0] e_m, input logic [32:0] e_q,
                           input int e_lat, input int poke);
        int n;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back({e_z, e_hi, e_lo});
        @(negedge clk);
        start = 1'b0;
        check({name, "_div_m"}, 65'(div_m), 65'(e_m));
        check({name, "_div_q"}, 65'(div_q), 65'(e_q));
        check({name, "_busy"}, 65'(busy), 65'd1);
        n = 0;
        while (!done && n < 300) begin
            if (n == poke) begin
                start    = 1'b1;
                dividend = 32'd1;
                divisor  = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            check({name, "_timeout"}, 65'd0, 65'd1);
        end else begin
            check({name, "_latency"}, 65'(n), 65'(e_lat));
        end
        check({name, "_m_hold"}, 65'(div_m), 65'(e_m));
        repeat (3) @(negedge clk);
        check({name, "_hold"}, {div_zero, hi, lo}, {e_z, e_hi, e_lo});
        check({name, "_idle"}, 65'({busy, done}), 65'd0);
    endtask

    initial begin
        clr_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset_outs", {div_zero, hi, lo}, 65'd0);
        check("reset_ops", 65'({div_m, div_q}), 65'd0);
        check("reset_flags", 65'({busy, done}), 65'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        run_div("p_p", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33'd7, 33'd100, LAT, -1);
        run_div("n_p", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33'd7, 33'd100, LAT, -1);
        run_div("p_n", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 33'd7, 33'd100, LAT, -1);
        run_div("n_n", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 33'd7, 33'd100, LAT, -1);
        run_div("m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33'd2, 33'd7, LAT, -1);
        run_div("minint", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0,
                33'd1, 33'h080000000, LAT, -1);
`ifdef DIV_ZERO_TRAP_EN
        run_div("zero", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 33'd0, 33'd5, 0, -1);
        // a normal capture clears the flag again
        run_div("after_zero", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33'd6, 33'd20, LAT, -1);
`else
        run_div("zero", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 33'd0, 33'd5, LAT, -1);
`endif
        // start during WAIT is ignored: one done, original operands and latency
        run_div("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33'd7, 33'd100, LAT, 5);

        // reset in the middle of WAIT aborts with no done
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("abort_outs", {div_zero, hi, lo}, 65'd0);
        check("abort_ops", 65'({div_m, div_q}), 65'd0);
        check("abort_flags", 65'({busy, done}), 65'd0);
        repeat (LAT + 5) @(negedge clk);
        clr_n = 1'b1;
        run_div("post_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33'd3, 33'd9, LAT, -1);

        repeat (LAT + 5) @(negedge clk);
        check("queue_empty", 65'(exp_q.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
